fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
Shares one single-ported, synchronous-read memory between the instruction fetch stage and the load/store unit. Data accesses have priority. A streak counter guarantees that fetch gets a slot after MAX_STREAK consecutive data grants. The block produces the fetch stage's stall input and routes each one-cycle-latency read response back to the requester that owns it. It sits between stage_fetch, the LSU and the unified memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_STREAK, 3, max consecutive data grants before fetch is forced; must be at least 1

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous, active-high reset
f_addr  in  ADDR_W  fetch address (fetchpc from fetch stage)
f_flush  in  1  squash the in-flight fetch response (redirect)
f_stall  out  1  to fetch stage stall input; 1 = fetch not granted this cycle
f_rdata  out  DATA_W  fetched instruction word
f_rvalid  out  1  f_rdata valid
d_req  in  1  data access request, held until d_ack
d_we  in  1  1 = write
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_wstrb  in  DATA_W/8  byte write strobes
d_ack  out  1  data request granted this cycle
d_rdata  out  DATA_W  load data
d_rvalid  out  1  load data valid
m_en  out  1  memory access enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  DATA_W/8  memory byte strobes
m_rdata  in  DATA_W  memory read data, valid the cycle after m_en with m_we=0

Behaviour:
- Grant is combinational in cycle N.
  - grant_d = ~rst & d_req & (streak < MAX_STREAK).
  - grant_f = ~rst & ~grant_d. Fetch always requests.
- Memory outputs in cycle N:
  - m_en = grant_d | grant_f.
  - Memory inputs take the granted requester's signals.
  - m_we = grant_d & d_we; m_wstrb = 0 unless a data write is granted.
- Handshakes:
  - d_ack = grant_d.
  - f_stall = ~grant_f, so fetch holds presentpc.
  - The LSU holds d_* stable while d_req=1 and d_ack=0.
- Owner register: {NONE, FETCH, DATA}, updated each cycle.
  - Becomes FETCH on grant_f.
  - Becomes DATA on a granted data read.
  - Becomes NONE on a data write or on rst.
- Response in cycle N+1:
  - f_rvalid = (owner==FETCH) & ~flushed.
  - d_rvalid = (owner==DATA).
  - f_rdata and d_rdata both = m_rdata.
  - Writes produce no d_rvalid; they complete at d_ack.
- Flush handling:
  - A flushed flag is set when f_flush=1 and owner==FETCH is being assigned that cycle.
  - f_flush asserted in the response cycle also forces f_rvalid=0.
- Streak counter, width clog2(MAX_STREAK+1):
  - Increments on grant_d, saturating at MAX_STREAK.
  - Clears on grant_f.
- Reset values:
  - streak=0, owner=NONE, flushed=0.
  - f_stall=1, d_ack=0, m_en=0, f_rvalid=0, d_rvalid=0.
- Reset mid-operation: any in-flight response is dropped, with no rvalid in the following cycle. After rst deasserts, the first cycle grants fetch unless d_req is present.
- Simultaneous f_flush and grant_f in the same cycle: the new fetch is squashed and the stall behaviour is unchanged.
- Throughput: one access per cycle; memory is never idle while not in reset.

Decomposition:
- Shared package: owner enum (OWN_NONE, OWN_FETCH, OWN_DATA) and the memory request struct (en, we, addr, wdata, wstrb). The LSU and memory model reuse both.
- One natural sub-module: streak_counter, a saturating counter with inc and clr inputs and MAX parameter.

Test Plan:
- Reset held 3 cycles with d_req=1 -> f_stall=1, d_ack=0, m_en=0 throughout; first cycle after release grants data: d_ack=1, streak=1.
- d_req=0, f_addr=0x100 -> m_addr=0x100, f_stall=0; next cycle f_rvalid=1 and f_rdata=mem[0x100].
- d_req held high for 10 cycles (reads, MAX_STREAK=3) -> grant pattern D,D,D,F repeating; d_rvalid follows each d_ack by 1 cycle; f_stall=1 only on D cycles.
- Data write: addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF -> m_we=1, d_ack=1, no d_rvalid next cycle; a later read of 0x2000 returns 0xDEADBEEF.
- f_flush=1 in the same cycle as a fetch grant -> next cycle f_rvalid=0; following fetch responses are normal.
- rst asserted in the cycle after a data read grant -> d_rvalid=0 that cycle and owner=NONE.

Source files
------------

// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types for the fetch/LSU memory arbiter: response owner tags and the
// memory request bundle, also reused by the LSU and the memory model.
package fetch_mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic                    en;
        logic                    we;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] wstrb;
    } mem_req_t;

    function automatic int streak_w(input int max_streak);
        return $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// Bus bundle between the arbiter (slave view) and fetch stage, LSU and memory
// (master view). owner_dbg/streak_dbg expose internal state for checkers.
interface fetch_mem_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 3
) ();
    import fetch_mem_arbiter_pkg::*;

    localparam int STREAK_W = streak_w(MAX_STREAK);

    // Handshakes: fetch always requests and is granted when f_stall=0; the LSU
    // raises d_req and holds d_* stable until the cycle d_ack=1 (transfer
    // cycle). Read data returns one cycle after grant with f_rvalid/d_rvalid.
    logic [ADDR_W-1:0]   f_addr;
    logic                f_flush;
    logic                f_stall;
    logic [DATA_W-1:0]   f_rdata;
    logic                f_rvalid;

    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_ack;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_rvalid;

    logic                m_en;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic [DATA_W-1:0]   m_rdata;

    owner_t              owner_dbg;
    logic [STREAK_W-1:0] streak_dbg;

    modport slave (
        input  f_addr, f_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
        output f_stall, f_rdata, f_rvalid, d_ack, d_rdata, d_rvalid,
               m_en, m_we, m_addr, m_wdata, m_wstrb, owner_dbg, streak_dbg
    );

    modport master (
        output f_addr, f_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
        input  f_stall, f_rdata, f_rvalid, d_ack, d_rdata, d_rvalid,
               m_en, m_we, m_addr, m_wdata, m_wstrb, owner_dbg, streak_dbg
    );

endinterface

// File: rtl/fetch_mem_arbiter_streak_counter.sv
// Saturating up-counter tracking consecutive data grants; clr wins over inc.
module streak_counter #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CMAX = W'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != CMAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates a single-ported synchronous-read memory between instruction
// fetch and the LSU; data wins until the streak limit forces a fetch slot.
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MAX_STREAK = 3
) (
    input logic                clk,
    input logic                rst,
    fetch_mem_arbiter_if.slave bus
);

    localparam int                   STREAK_W   = streak_w(MAX_STREAK);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [ADDR_W-1:0]    NO_ADDR    = '0;
    localparam logic [DATA_W-1:0]    NO_DATA    = '0;
    localparam logic [DATA_W/8-1:0]  NO_STRB    = '0;

    logic                grant_d;
    logic                grant_f;
    logic [STREAK_W-1:0] streak;
    owner_t              owner;
    owner_t              owner_next;
    logic                flushed;
    logic                flushed_next;
    mem_req_t            req;

    assign grant_d = ~rst & bus.d_req & (streak < STREAK_MAX);
    assign grant_f = ~rst & ~grant_d;

    streak_counter #(.MAX(MAX_STREAK), .W(STREAK_W)) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (grant_d),
        .clr   (grant_f),
        .count (streak)
    );

    always_comb begin
        req = '{en: 1'b0, we: 1'b0, addr: NO_ADDR, wdata: NO_DATA, wstrb: NO_STRB};
        if (grant_d) begin
            req.en    = 1'b1;
            req.we    = bus.d_we;
            req.addr  = bus.d_addr;
            req.wdata = bus.d_wdata;
            req.wstrb = bus.d_we ? bus.d_wstrb : NO_STRB;
        end else if (grant_f) begin
            req.en   = 1'b1;
            req.addr = bus.f_addr;
        end
    end

    // Owner tags which requester the next-cycle m_rdata belongs to; writes
    // return nothing, so they leave the slot unowned.
    always_comb begin
        owner_next   = OWN_NONE;
        flushed_next = 1'b0;
        if (grant_f) begin
            owner_next   = OWN_FETCH;
            flushed_next = bus.f_flush;
        end else if (grant_d && !bus.d_we) begin
            owner_next = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= OWN_NONE;
            flushed <= 1'b0;
        end else begin
            owner   <= owner_next;
            flushed <= flushed_next;
        end
    end

    assign bus.m_en    = req.en;
    assign bus.m_we    = req.we;
    assign bus.m_addr  = req.addr;
    assign bus.m_wdata = req.wdata;
    assign bus.m_wstrb = req.wstrb;

    assign bus.d_ack   = grant_d;
    assign bus.f_stall = ~grant_f;

    // rst gating drops a response whose owner was captured before reset.
    assign bus.f_rvalid = ~rst & (owner == OWN_FETCH) & ~flushed & ~bus.f_flush;
    assign bus.d_rvalid = ~rst & (owner == OWN_DATA);
    assign bus.f_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    assign bus.owner_dbg  = owner;
    assign bus.streak_dbg = streak;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter with a byte-strobed synchronous memory model.
module tb_fetch_mem_arbiter;
    import fetch_mem_arbiter_pkg::*;

    localparam logic [31:0] W100 = 32'h1234_5678;
    localparam logic [31:0] W104 = 32'h9ABC_DEF0;
    localparam logic [31:0] W300 = 32'hA5A5_0300;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(3)) bus ();

    fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] mem_word;

    always @(posedge clk) begin
        if (bus.m_en) begin
            mem_word = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'h0;
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.m_wstrb[b]) mem_word[b*8 +: 8] = bus.m_wdata[b*8 +: 8];
                end
                mem[bus.m_addr] = mem_word;
            end else begin
                bus.m_rdata <= mem_word;
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            cycle(); #1;
            checks++; if (bus.f_stall !== 1'b1) begin errors++; $display("FAIL reset_f_stall cyc%0d got %b want 1", i, bus.f_stall); end
            checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack cyc%0d got %b want 0", i, bus.d_ack); end
            checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL reset_m_en cyc%0d got %b want 0", i, bus.m_en); end
            checks++; if ({bus.f_rvalid, bus.d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid cyc%0d got %b want 00", i, {bus.f_rvalid, bus.d_rvalid}); end
        end
        cycle(); rst = 1'b0; #1;
        checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL release_d_ack got %b want 1", bus.d_ack); end
        checks++; if (bus.m_addr !== 32'h300) begin errors++; $display("FAIL release_m_addr got %h want 300", bus.m_addr); end
        cycle(); bus.d_req = 1'b0; #1;
        checks++; if (bus.streak_dbg !== 2'd1) begin errors++; $display("FAIL release_streak got %0d want 1", bus.streak_dbg); end
        checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL release_d_rvalid got %b want 1", bus.d_rvalid); end
        checks++; if (bus.d_rdata !== W300) begin errors++; $display("FAIL release_d_rdata got %h want %h", bus.d_rdata, W300); end
    endtask

    task automatic test_fetch();
        cycle(); bus.d_req = 1'b0; bus.f_addr = 32'h100; #1;
        checks++; if (bus.m_addr !== 32'h100) begin errors++; $display("FAIL fetch_m_addr got %h want 100", bus.m_addr); end
        checks++; if (bus.f_stall !== 1'b0) begin errors++; $display("FAIL fetch_f_stall got %b want 0", bus.f_stall); end
        checks++; if ({bus.m_en, bus.m_we} !== 2'b10) begin errors++; $display("FAIL fetch_m_en_we got %b want 10", {bus.m_en, bus.m_we}); end
        cycle(); bus.f_addr = 32'h104; #1;
        checks++; if (bus.f_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_f_rvalid got %b want 1", bus.f_rvalid); end
        checks++; if (bus.f_rdata !== W100) begin errors++; $display("FAIL fetch_f_rdata got %h want %h", bus.f_rdata, W100); end
    endtask

    task automatic test_data_streak();
        logic prev_d;
        logic exp_d;
        prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.f_addr = 32'h100;
            #1;
            exp_d = ((i % 4) != 3);
            checks++; if (bus.d_ack !== exp_d) begin errors++; $display("FAIL streak_d_ack cyc%0d got %b want %b", i, bus.d_ack, exp_d); end
            checks++; if (bus.f_stall !== exp_d) begin errors++; $display("FAIL streak_f_stall cyc%0d got %b want %b", i, bus.f_stall, exp_d); end
            checks++; if ({bus.d_rvalid, bus.f_rvalid} !== {prev_d, ~prev_d}) begin errors++; $display("FAIL streak_rvalid cyc%0d got %b want %b", i, {bus.d_rvalid, bus.f_rvalid}, {prev_d, ~prev_d}); end
            if (prev_d) begin
                checks++; if (bus.d_rdata !== W300) begin errors++; $display("FAIL streak_d_rdata cyc%0d got %h want %h", i, bus.d_rdata, W300); end
            end else begin
                checks++; if (bus.f_rdata !== ((i == 0) ? W104 : W100)) begin errors++; $display("FAIL streak_f_rdata cyc%0d got %h", i, bus.f_rdata); end
            end
            prev_d = exp_d;
        end
        cycle(); bus.d_req = 1'b0; #1;
        checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL streak_last_d_rvalid got %b want 1", bus.d_rvalid); end
    endtask

    task automatic test_write();
        cycle();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
        #1;
        checks++; if ({bus.d_ack, bus.m_we} !== 2'b11) begin errors++; $display("FAIL write_ack_we got %b want 11", {bus.d_ack, bus.m_we}); end
        checks++; if (bus.m_wstrb !== 4'hF) begin errors++; $display("FAIL write_m_wstrb got %h want f", bus.m_wstrb); end
        checks++; if (bus.m_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_m_wdata got %h want deadbeef", bus.m_wdata); end
        cycle(); bus.d_we = 1'b0; bus.d_wstrb = 4'hF; #1;
        checks++; if ({bus.d_rvalid, bus.f_rvalid} !== 2'b00) begin errors++; $display("FAIL write_no_rvalid got %b want 00", {bus.d_rvalid, bus.f_rvalid}); end
        checks++; if ({bus.d_ack, bus.m_we, bus.m_wstrb} !== 6'b10_0000) begin errors++; $display("FAIL read_ack_we_strb got %b want 100000", {bus.d_ack, bus.m_we, bus.m_wstrb}); end
        cycle(); bus.d_req = 1'b0; #1;
        checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL readback_d_rvalid got %b want 1", bus.d_rvalid); end
        checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL readback_d_rdata got %h want deadbeef", bus.d_rdata); end
    endtask

    task automatic test_flush();
        cycle(); bus.f_addr = 32'h100; bus.f_flush = 1'b1; #1;
        checks++; if (bus.f_stall !== 1'b0) begin errors++; $display("FAIL flush_f_stall got %b want 0", bus.f_stall); end
        checks++; if (bus.m_addr !== 32'h100) begin errors++; $display("FAIL flush_m_addr got %h want 100", bus.m_addr); end
        cycle(); bus.f_flush = 1'b0; bus.f_addr = 32'h104; #1;
        checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL flush_squash got %b want 0", bus.f_rvalid); end
        cycle(); bus.f_addr = 32'h100; #1;
        checks++; if (bus.f_rvalid !== 1'b1) begin errors++; $display("FAIL flush_resume_rvalid got %b want 1", bus.f_rvalid); end
        checks++; if (bus.f_rdata !== W104) begin errors++; $display("FAIL flush_resume_rdata got %h want %h", bus.f_rdata, W104); end
        cycle(); bus.f_flush = 1'b1; bus.f_addr = 32'h104; #1;
        checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL flush_resp_cycle got %b want 0", bus.f_rvalid); end
        cycle(); bus.f_flush = 1'b0; bus.f_addr = 32'h100; #1;
        checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL flush_second_squash got %b want 0", bus.f_rvalid); end
        cycle(); #1;
        checks++; if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, W100}) begin errors++; $display("FAIL flush_final got %b/%h want 1/%h", bus.f_rvalid, bus.f_rdata, W100); end
    endtask

    task automatic test_reset_mid();
        cycle(); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; #1;
        checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL mid_d_ack got %b want 1", bus.d_ack); end
        cycle(); rst = 1'b1; bus.d_req = 1'b0; #1;
        checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL mid_d_rvalid got %b want 0", bus.d_rvalid); end
        checks++; if ({bus.m_en, bus.f_stall} !== 2'b01) begin errors++; $display("FAIL mid_men_stall got %b want 01", {bus.m_en, bus.f_stall}); end
        cycle(); rst = 1'b0; bus.f_addr = 32'h104; #1;
        checks++; if (bus.owner_dbg !== OWN_NONE) begin errors++; $display("FAIL mid_owner got %0d want 0", bus.owner_dbg); end
        checks++; if ({bus.d_rvalid, bus.f_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_after_rvalid got %b want 00", {bus.d_rvalid, bus.f_rvalid}); end
        checks++; if ({bus.f_stall, bus.streak_dbg} !== 3'b000) begin errors++; $display("FAIL mid_after_stall_streak got %b want 000", {bus.f_stall, bus.streak_dbg}); end
        cycle(); #1;
        checks++; if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, W104}) begin errors++; $display("FAIL mid_fetch_resume got %b/%h want 1/%h", bus.f_rvalid, bus.f_rdata, W104); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem[32'h100] = W100;
        mem[32'h104] = W104;
        mem[32'h300] = W300;
        rst = 1'b1;
        bus.f_addr = 32'h0; bus.f_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;
        bus.m_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_data_streak();
        test_write();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
